// File: rtl/demorgan_sweep_checker_if.sv
// Bus bundle for demorgan_sweep_checker.
//   master: drives start, abort, inject_en, inject_mask; observes results.
//   slave : the checker; consumes controls, drives vectors, stage-1 results,
//           status (busy/done/pass) and error record (err_count, first_err_*).
interface demorgan_sweep_checker_if #(
   parameter int WIDTH = 2,
   parameter int ERRW  = 16
);
   logic             start;
   logic             abort;
   logic             inject_en;
   logic [WIDTH-1:0] inject_mask;
   logic [WIDTH-1:0] vec_a;
   logic [WIDTH-1:0] vec_b;
   logic [WIDTH-1:0] nandnb;
   logic [WIDTH-1:0] nor_ab;
   logic [WIDTH-1:0] nornb;
   logic [WIDTH-1:0] nand_ab;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERRW-1:0]  err_count;
   logic             first_err_valid;
   logic [WIDTH-1:0] first_err_a;
   logic [WIDTH-1:0] first_err_b;

   modport master (
      output start, abort, inject_en, inject_mask,
      input  vec_a, vec_b, nandnb, nor_ab, nornb, nand_ab,
             busy, done, pass, err_count, first_err_valid, first_err_a, first_err_b
   );

   modport slave (
      input  start, abort, inject_en, inject_mask,
      output vec_a, vec_b, nandnb, nor_ab, nornb, nand_ab,
             busy, done, pass, err_count, first_err_valid, first_err_a, first_err_b
   );
endinterface

// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: exhaustively sweeps all {A,B} operand pairs through
// both De Morgan identity pairs, compares them in a 2-stage pipeline, counts
// mismatching vectors (saturating) and records the first failing vector.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of demorgan_sweep_checker_if (controls in, results out)

// One bit lane: combinational results for a single operand bit.
module demorgan_lane (
   input  logic a,
   input  logic b,
   input  logic inj,
   output logic nandnb,
   output logic nor_ab,
   output logic nornb,
   output logic nand_ab
);
   assign nandnb  = (~a & ~b) ^ inj;
   assign nor_ab  = ~(a | b);
   assign nornb   = ~a | ~b;
   assign nand_ab = ~(a & b);
endmodule

module demorgan_sweep_checker #(
   parameter int WIDTH = 2,
   parameter int ERRW  = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   demorgan_sweep_checker_if.slave bus
);
   localparam int CW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // stage-1 capture: operand copy plus the four bitwise results
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] nandnb;
      logic [WIDTH-1:0] nor_ab;
      logic [WIDTH-1:0] nornb;
      logic [WIDTH-1:0] nand_ab;
   } s1_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] va, vb, inj;
   s1_t              s1_in, s1;
   logic             s1_vld;
   logic [ERRW-1:0]  err;
   logic             fev;
   logic [WIDTH-1:0] fea, feb;
   logic             pass_q;
   logic             start_hit, abort_hit, last, mism;

   assign {va, vb}  = cnt;
   assign inj       = bus.inject_en ? bus.inject_mask : '0;
   assign start_hit = (state == IDLE) && bus.start;
   assign abort_hit = ((state == RUN) || (state == DRAIN)) && bus.abort;
   assign last      = (cnt == {CW{1'b1}});

   assign s1_in.a = va;
   assign s1_in.b = vb;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      demorgan_lane u_lane (
         .a       (va[i]),
         .b       (vb[i]),
         .inj     (inj[i]),
         .nandnb  (s1_in.nandnb[i]),
         .nor_ab  (s1_in.nor_ab[i]),
         .nornb   (s1_in.nornb[i]),
         .nand_ab (s1_in.nand_ab[i])
      );
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_hit) state_nxt = RUN;
         RUN:     if (abort_hit) state_nxt = IDLE;
                  else if (last) state_nxt = DRAIN;
         DRAIN:   state_nxt = abort_hit ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // pass is live during the DONE cycle (err is final by then) and then held
   always_comb begin
      bus.busy = (state == RUN) || (state == DRAIN);
      bus.done = (state == DONE);
      bus.pass = (state == DONE) ? (err == '0) : pass_q;
   end

   // stimulus counter; holds at all-ones so it never wraps inside a sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    cnt <= '0;
      else if (start_hit)                            cnt <= '0;
      else if (state == RUN && !abort_hit && !last)  cnt <= cnt + CW'(1);
   end

   // stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         s1_vld <= 1'b0;
      end else begin
         if (state == RUN) s1 <= s1_in;
         s1_vld <= (state == RUN) && !abort_hit;
      end
   end

   // stage 2: one count per mismatching vector, however many bits differ
   assign mism = (|(s1.nandnb ^ s1.nor_ab)) || (|(s1.nornb ^ s1.nand_ab));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= '0;
         fev <= 1'b0;
         fea <= '0;
         feb <= '0;
      end else if (start_hit) begin
         err <= '0;
         fev <= 1'b0;
         fea <= '0;
         feb <= '0;
      end else if (s1_vld && mism) begin
         if (err != {ERRW{1'b1}}) err <= err + ERRW'(1);
         if (!fev) begin
            fev <= 1'b1;
            fea <= s1.a;
            feb <= s1.b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               pass_q <= 1'b0;
      else if (start_hit)       pass_q <= 1'b0;
      else if (abort_hit)       pass_q <= 1'b0;
      else if (state == DONE)   pass_q <= (err == '0);
   end

   assign bus.vec_a           = va;
   assign bus.vec_b           = vb;
   assign bus.nandnb          = s1.nandnb;
   assign bus.nor_ab          = s1.nor_ab;
   assign bus.nornb           = s1.nornb;
   assign bus.nand_ab         = s1.nand_ab;
   assign bus.err_count       = err;
   assign bus.first_err_valid = fev;
   assign bus.first_err_a     = fea;
   assign bus.first_err_b     = feb;
endmodule

// File: doc/demorgan_sweep_checker.md
Name: demorgan_sweep_checker

Overview:
- Parametrised, self-checking successor to the single-bit De Morgan gate pair.
- On a start request, sweeps every combination of two WIDTH-bit operands through both De Morgan identity pairs, bitwise:
  - form 1: ~A&~B vs ~(A|B)
  - form 2: ~A|~B vs ~(A&B)
- Compares each pair in a 2-stage pipeline, counts mismatching vectors and records the first failing vector.
- Serves as the built-in logic-check block in the gate-level lab datapath. A fault-injection input lets the bench prove that the checker detects errors.

Parameters:
WIDTH, 2, bits per operand; the sweep covers N = 2^(2*WIDTH) vectors
ERRW, 16, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled in IDLE only
abort  input  1  cancel a sweep in progress; sampled in RUN/DRAIN
inject_en  input  1  apply inject_mask to the form-1 result of the vector currently presented
inject_mask  input  WIDTH  XOR mask on the ~A&~B result when inject_en=1
vec_a  output  WIDTH  operand A currently presented
vec_b  output  WIDTH  operand B currently presented
nandnb  output  WIDTH  registered ~A&~B (stage 1, after injection)
nor_ab  output  WIDTH  registered ~(A|B) (stage 1)
nornb  output  WIDTH  registered ~A|~B (stage 1)
nand_ab  output  WIDTH  registered ~(A&B) (stage 1)
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when a sweep completes normally
pass  output  1  high when the last completed sweep had err_count==0; held until the next start
err_count  output  ERRW  number of mismatching vectors, saturating
first_err_valid  output  1  a mismatch has been recorded this sweep
first_err_a  output  WIDTH  A of the first mismatching vector
first_err_b  output  WIDTH  B of the first mismatching vector

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - Stimulus counter, all stage-1 registers and all outputs go to 0.
  - pass is held at 0 until a sweep completes.
- Stimulus counter: 2*WIDTH bits; {vec_a,vec_b} = counter, with A in the MSBs.
- States:
  - IDLE: start=1 clears the counter, err_count, first_err_* and pass, then moves to RUN.
  - RUN, cycle i (i = 0..N-1 after the start edge): vector i is presented. Stage 1 captures the four results plus a valid bit at the end of cycle i. The compare stage updates the error state at the end of cycle i+1. After cycle N-1, move to DRAIN.
  - DRAIN: lasts 1 cycle (cycle N), in which the last compare completes; then move to DONE.
  - DONE: lasts 1 cycle (cycle N+1). done=1 and pass=(err_count==0); then return to IDLE.
  - busy=1 in RUN and DRAIN. Net latency: done is high in cycle N+1 after the start edge.
- Mismatch rule: a vector is counted once if (nandnb!=nor_ab) or (nornb!=nand_ab), regardless of how many bits differ.
  - err_count increments by 1 per counted vector and saturates at 2^ERRW-1.
  - On the first mismatch of a sweep, first_err_a/b are loaded from that vector's stage-1 operand copy and first_err_valid is set. Later mismatches do not overwrite them.
- Injection: the form-1 result is XORed with inject_mask only when inject_en=1 during that vector's presentation cycle. A mask of 0 has no effect.
- start while busy or in DONE: ignored.
- abort in RUN or DRAIN:
  - Next state is IDLE; the stage-1 valid bit is cleared.
  - done is not pulsed and pass=0.
  - err_count and first_err_* keep their partial values.
- abort and start asserted together in IDLE: start wins; abort is ignored outside RUN/DRAIN.
- Counter wrap: the counter never wraps inside a sweep; the RUN exit occurs at the all-ones value.
- Reset asserted mid-sweep: immediate return to the reset state; no done pulse.

Test Plan:
- WIDTH=2: start pulsed for 1 cycle, no injection -> busy high for 17 cycles, done pulses in cycle 17 after the start edge, pass=1, err_count=0, first_err_valid=0.
- WIDTH=2: inject_en=1 with mask=2'b01 only during cycle 5 -> done then pass=0, err_count=1, first_err_a=2'b01, first_err_b=2'b01.
- WIDTH=2, ERRW=3: inject_en=1 with mask=2'b11 for the whole sweep -> err_count saturates at 7, first_err_a=0, first_err_b=0, pass=0.
- WIDTH=2: abort in cycle 8 -> busy drops the next cycle, no done pulse, pass=0. A new start then completes a clean sweep with pass=1.
- start re-pulsed during RUN at cycle 3 -> ignored; done still occurs in cycle 17 from the original start edge.
- rst_n pulsed low asynchronously mid-sweep (cycle 10) -> all outputs 0 immediately, state IDLE, no done pulse.
